// File: rtl/fxp_pkg.sv
// ---------------------------------------------------------------------------
// fxp_pkg
// Shared fixed-point definitions for the Execution-stage reduction datapath.
// The default format is Q8.8. The accumulator and adder arithmetic do not
// depend on where the binary point sits.
// ---------------------------------------------------------------------------
package fxp_pkg;

    localparam int FXP_DATA_WIDTH = 16;
    localparam int FXP_FRAC_BITS  = 8;
    localparam int FXP_MAX_COUNT  = 16;

    typedef logic signed [FXP_DATA_WIDTH-1:0] fxp_t;

    // Saturation limits for the default word width.
    localparam fxp_t FXP_MAX = {1'b0, {(FXP_DATA_WIDTH-1){1'b1}}};
    localparam fxp_t FXP_MIN = {1'b1, {(FXP_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/fxp_accumulator_if.sv
// ---------------------------------------------------------------------------
// fxp_accumulator_if
// Element stream in and reduction result out. Both directions use a
// valid/ready handshake.
//   in_valid/in_ready/in_data/in_last : element stream into the accumulator
//   out_valid/out_ready               : result handshake toward the consumer
//   out_data/out_n/out_v/out_z        : saturated sum and its N/V/Z flags
//   out_count                         : elements folded into this result
// The master modport belongs to the producer/consumer side. The slave
// modport belongs to the accumulator.
// ---------------------------------------------------------------------------
interface fxp_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_n;
    logic                  out_v;
    logic                  out_z;
    logic [CNT_W-1:0]      out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_n, out_v, out_z, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_n, out_v, out_z, out_count
    );
endinterface

// File: rtl/fxp_sat_add.sv
// ---------------------------------------------------------------------------
// fxp_sat_add
// Combinational signed addition that saturates to the representable range.
// Other lanes can reuse it.
//   i_a, i_b : signed operands
//   o_sum    : a+b clamped to [most negative, most positive]
//   o_ovf    : high when the true sum did not fit and o_sum was clamped
// ---------------------------------------------------------------------------
module fxp_sat_add
    import fxp_pkg::*;
#(
    parameter int W = FXP_DATA_WIDTH
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] w_wide;

    // Sign-extend both operands by one bit so the sum cannot wrap.
    assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};

    // The result overflowed when the extra sign bit disagrees with the
    // top bit of the W-bit result. The extra bit then holds the true sign.
    assign o_ovf = w_wide[W] ^ w_wide[W-1];

    // NOTE: every path assigns o_sum, so no latch is inferred.
    always_comb begin
        o_sum = w_wide[W-1:0];
        if (o_ovf) begin
            o_sum = w_wide[W] ? SAT_MIN : SAT_MAX;
        end
    end
endmodule

// File: rtl/fxp_accumulator.sv
// ---------------------------------------------------------------------------
// fxp_accumulator
// Sequential saturating accumulator. It folds a burst of signed fixed-point
// elements into one sum and holds that sum, with N/V/Z flags, until the
// consumer accepts it.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : fxp_accumulator_if.slave (element stream in, result out)
// A beat is the last beat of a burst when in_last is high, or when it is
// the MAX_COUNT-th element of the burst.
// ---------------------------------------------------------------------------
module fxp_accumulator
    import fxp_pkg::*;
#(
    parameter int DATA_WIDTH = FXP_DATA_WIDTH,
    parameter int FRAC_BITS  = FXP_FRAC_BITS,
    parameter int MAX_COUNT  = FXP_MAX_COUNT,
    parameter int CNT_W      = $clog2(MAX_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    fxp_accumulator_if.slave     bus
);
    // The binary point does not affect the arithmetic. It only has to lie
    // inside the word.
    if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac_bits
        $error("fxp_accumulator: FRAC_BITS must lie within DATA_WIDTH");
    end

    acc_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_v;
    logic [CNT_W-1:0]      r_count;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_n;
    logic                  r_out_v;
    logic                  r_out_z;
    logic [CNT_W-1:0]      r_out_count;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_ovf;
    logic                  w_v_next;
    logic [CNT_W-1:0]      w_count_next;

    fxp_sat_add #(
        .W (DATA_WIDTH)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (bus.in_data),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // rst gates in_ready directly. The block then refuses elements for as
    // long as rst is high, and accepts them as soon as rst is released.
    assign w_in_ready   = !rst && (r_state != HOLD);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_last       = bus.in_last || (r_count == CNT_W'(MAX_COUNT - 1));
    assign w_v_next     = r_v | w_ovf;
    assign w_count_next = r_count + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever order the lines are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_v         <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_n     <= 1'b0;
            r_out_v     <= 1'b0;
            r_out_z     <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                // r_acc is zero in IDLE, so IDLE and ACCUM share the update.
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_v     <= w_v_next;
                        r_count <= w_count_next;
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_sum;
                            r_out_n     <= w_sum[DATA_WIDTH-1];
                            r_out_v     <= w_v_next;
                            r_out_z     <= (w_sum == '0);
                            r_out_count <= w_count_next;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_acc       <= '0;
                        r_v         <= 1'b0;
                        r_count     <= '0;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_out_n     <= 1'b0;
                        r_out_v     <= 1'b0;
                        r_out_z     <= 1'b0;
                        r_out_count <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_n     = r_out_n;
    assign bus.out_v     = r_out_v;
    assign bus.out_z     = r_out_z;
    assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_fxp_accumulator.sv
module tb_fxp_accumulator;
    import fxp_pkg::*;

    localparam int DW    = 16;
    localparam int MAXC  = 16;
    localparam int CW    = 5;
    localparam int NVEC  = 4;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    fxp_accumulator_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    fxp_accumulator #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (8),
        .MAX_COUNT  (MAXC),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          n;
        logic        use_last;
        logic [15:0] beats [MAXC];
        logic [15:0] exp_data;
        logic        exp_n;
        logic        exp_v;
        logic        exp_z;
        int          exp_count;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one element and wait (bounded) until it is accepted. Returns
    // 1 time unit after the accepting clock edge.
    task automatic push(input logic [15:0] d, input logic last);
        int waits = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready stayed 0, expected 1");
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [15:0] d, input logic n,
                                input logic v, input logic z, input int cnt);
        check({name, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({name, ".data"},  32'(bus.out_data),  32'(d));
        check({name, ".n"},     32'(bus.out_n),     32'(n));
        check({name, ".v"},     32'(bus.out_v),     32'(v));
        check({name, ".z"},     32'(bus.out_z),     32'(z));
        check({name, ".count"}, 32'(bus.out_count), 32'(cnt));
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({name, ".released"}, 32'(bus.out_valid), 32'd0);
    endtask

    function automatic vec_t mk(input int n, input logic ul, input logic [15:0] b0,
                                input logic [15:0] b1, input logic [15:0] b2,
                                input logic [15:0] ed, input logic en, input logic ev,
                                input logic ez);
        vec_t r;
        r.n = n; r.use_last = ul;
        for (int i = 0; i < MAXC; i++) r.beats[i] = 16'h0000;
        r.beats[0] = b0; r.beats[1] = b1; r.beats[2] = b2;
        r.exp_data = ed; r.exp_n = en; r.exp_v = ev; r.exp_z = ez; r.exp_count = n;
        return r;
    endfunction

    initial begin
        int          acc;
        logic        sat;
        int          n;
        logic [15:0] d;
        logic        ul;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = mk(2, 1'b1, 16'h3219, 16'h197D, 16'h0, 16'h4B96, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(3, 1'b1, 16'h7F00, 16'h0200, 16'hFF00, 16'h7EFF, 1'b0, 1'b1, 1'b0);
        vecs[2] = mk(2, 1'b1, 16'h8100, 16'hFE00, 16'h0, 16'h8000, 1'b1, 1'b1, 1'b0);
        vecs[3] = mk(2, 1'b1, 16'h0100, 16'hFF00, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Reset state
        #12;
        check("rst.in_ready",  32'(bus.in_ready),  32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_data",  32'(bus.out_data),  32'd0);
        check("rst.out_z",     32'(bus.out_z),     32'd0);
        check("rst.out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.released_in_ready", 32'(bus.in_ready), 32'd1);

        // Table-driven reductions. The result is checked right after the
        // last beat's edge, which also covers the 1-cycle latency.
        for (int k = 0; k < NVEC; k++) begin
            for (int i = 0; i < vecs[k].n; i++)
                push(vecs[k].beats[i], vecs[k].use_last && (i == vecs[k].n - 1));
            check_result($sformatf("vec%0d", k), vecs[k].exp_data, vecs[k].exp_n,
                         vecs[k].exp_v, vecs[k].exp_z, vecs[k].exp_count);
            release_result($sformatf("vec%0d", k));
        end

        // Implicit last after MAX_COUNT beats, then backpressure with a
        // pending 17th beat
        for (int i = 0; i < MAXC; i++) push(16'h0100, 1'b0);
        check_result("implicit", 16'h1000, 1'b0, 1'b0, 1'b0, 16);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0080;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp.in_ready",  32'(bus.in_ready),  32'd0);
            check("bp.out_valid", 32'(bus.out_valid), 32'd1);
            check("bp.out_data",  32'(bus.out_data),  32'h1000);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp.release_valid", 32'(bus.out_valid), 32'd0);
        check("bp.release_ready", 32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_result("bp.fresh", 16'h0080, 1'b0, 1'b0, 1'b0, 1);
        release_result("bp.fresh");

        // out_ready while idle is ignored
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("idle_ready.out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Async reset mid-hold
        push(16'h0200, 1'b1);
        check_result("pre_rst_hold", 16'h0200, 1'b0, 1'b0, 1'b0, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_hold.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_hold.out_data",  32'(bus.out_data),  32'd0);
        check("rst_hold.out_count", 32'(bus.out_count), 32'd0);
        check("rst_hold.in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-burst
        push(16'h0100, 1'b0);
        push(16'h0100, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_burst.in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_burst.out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(16'h0300, 1'b1);
        check_result("post_rst", 16'h0300, 1'b0, 1'b0, 1'b0, 1);
        release_result("post_rst");

        // Randomised reductions against a plain-integer clamp model
        for (int r = 0; r < 40; r++) begin
            n   = $urandom_range(1, MAXC);
            ul  = (n < MAXC) ? 1'b1 : 1'($urandom_range(0, 1));
            acc = 0;
            sat = 1'b0;
            for (int i = 0; i < n; i++) begin
                d = 16'($urandom_range(0, 65535));
                acc = acc + int'($signed(d));
                if (acc > 32767)  begin acc = 32767;  sat = 1'b1; end
                if (acc < -32768) begin acc = -32768; sat = 1'b1; end
                push(d, ul && (i == n - 1));
            end
            check_result($sformatf("rand%0d", r), 16'(acc), acc < 0, sat, acc == 0, n);
            for (int w = $urandom_range(0, 2); w > 0; w--) @(negedge clk);
            release_result($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
